// File: rtl/cal_ctrl_if.sv
// Byte-in / word-out link between the UART and the calculator controller.
// The master side drives received bytes; the slave side returns results and error strobes.
interface cal_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        err;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, tx_valid, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, tx_valid, err
  );
endinterface

// File: rtl/cal_ctrl.sv
// ASCII expression calculator: parses "A op B term" from UART bytes and emits
// a 32-bit result or a one-cycle error strobe.
module cal_ctrl (
  input logic       clk,
  input logic       n_rst,
  cal_ctrl_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int OPER_W = 16;
  localparam int RES_W  = 32;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] OPA  = 3'd1;
  localparam logic [2:0] OPB  = 3'd2;
  localparam logic [2:0] CALC = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [DATA_W-1:0] CH_ADD   = 8'h2B;
  localparam logic [DATA_W-1:0] CH_SUB   = 8'h2D;
  localparam logic [DATA_W-1:0] CH_MUL   = 8'h2A;
  localparam logic [DATA_W-1:0] CH_EQ    = 8'h3D;
  localparam logic [DATA_W-1:0] CH_CR    = 8'h0D;
  localparam logic [DATA_W-1:0] CH_SPACE = 8'h20;

  function automatic logic is_digit(input logic [DATA_W-1:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_op(input logic [DATA_W-1:0] c);
    return (c == CH_ADD) || (c == CH_SUB) || (c == CH_MUL);
  endfunction

  function automatic logic is_term(input logic [DATA_W-1:0] c);
    return (c == CH_EQ) || (c == CH_CR);
  endfunction

  // Decimal accumulate, wrapping modulo 2^16.
  function automatic logic [OPER_W-1:0] acc10(input logic [OPER_W-1:0] v,
                                               input logic [DATA_W-1:0] c);
    logic [OPER_W-1:0] scaled;
    scaled = v * 16'd10;
    return scaled + {12'd0, c[3:0]};
  endfunction

  function automatic logic [RES_W-1:0] calc_res(input logic [DATA_W-1:0] opc,
                                                input logic [OPER_W-1:0] x,
                                                input logic [OPER_W-1:0] y);
    logic [RES_W-1:0] xe;
    logic [RES_W-1:0] ye;
    xe = {16'd0, x};
    ye = {16'd0, y};
    case (opc)
      CH_SUB:  return xe - ye;
      CH_MUL:  return xe * ye;
      default: return xe + ye;
    endcase
  endfunction

  logic [DATA_W-1:0] rx_p0;
  logic              vld_p0;
  logic [2:0]        state;
  logic [OPER_W-1:0] a_val;
  logic [OPER_W-1:0] b_val;
  logic [DATA_W-1:0] op_code;
  logic              b_seen;

  // Stage p0: register the incoming byte; spaces are filtered out here.
  always_ff @(posedge clk) begin
    rx_p0 <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) vld_p0 <= 1'b0;
    else        vld_p0 <= bus.rx_valid && (bus.rx_data != CH_SPACE);
  end

  // Stage p1: parser FSM and result register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      a_val        <= '0;
      b_val        <= '0;
      op_code      <= CH_ADD;
      b_seen       <= 1'b0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.tx_valid <= 1'b0;
      bus.err      <= 1'b0;
      if (state == CALC) begin
        bus.tx_data  <= calc_res(op_code, a_val, b_val);
        bus.tx_valid <= 1'b1;
        state        <= IDLE;
      end else if (vld_p0) begin
        case (state)
          IDLE: begin
            if (is_digit(rx_p0)) begin
              a_val <= {12'd0, rx_p0[3:0]};
              state <= OPA;
            end else if (!is_term(rx_p0)) begin
              state <= ERR;
            end
          end
          OPA: begin
            if (is_digit(rx_p0)) begin
              a_val <= acc10(a_val, rx_p0);
            end else if (is_op(rx_p0)) begin
              op_code <= rx_p0;
              b_val   <= '0;
              b_seen  <= 1'b0;
              state   <= OPB;
            end else if (is_term(rx_p0)) begin
              // A rejecting term also closes the expression.
              bus.err <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= ERR;
            end
          end
          OPB: begin
            if (is_digit(rx_p0)) begin
              b_val  <= acc10(b_val, rx_p0);
              b_seen <= 1'b1;
            end else if (is_term(rx_p0)) begin
              if (b_seen) begin
                state <= CALC;
              end else begin
                bus.err <= 1'b1;
                state   <= IDLE;
              end
            end else begin
              state <= ERR;
            end
          end
          default: begin
            if (is_term(rx_p0)) begin
              bus.err <= 1'b1;
              state   <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
